// File: rtl/la_pwrseq_pkg.sv
// Shared definitions for the la_pwrseq power-domain sequencer.
// Holds the state encodings, the default cycle constants, and the state-to-driver
// level table that both the top-level FSM and its output registers use.
package la_pwrseq_pkg;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_PUP    = 3'd1,
      ST_RSTREL = 3'd2,
      ST_ISOREL = 3'd3,
      ST_ON     = 3'd4,
      ST_ISOSET = 3'd5,
      ST_RSTSET = 3'd6,
      ST_PDN    = 3'd7
   } state_e;

   localparam int DEF_CW            = 8;
   localparam int DEF_SWITCH_CYCLES = 4;
   localparam int DEF_RST_CYCLES    = 2;
   localparam int DEF_ISO_CYCLES    = 3;
   localparam int DEF_TIMEOUT       = 16;

   // Levels driven into the switched domain.
   typedef struct packed {
      logic pwr_en;
      logic dom_nreset;
      logic iso_en;
      logic ack;
   } drv_t;

   // Safe levels: supply off, domain held in reset, outputs clamped.
   localparam drv_t DRV_SAFE = '{pwr_en: 1'b0, dom_nreset: 1'b0, iso_en: 1'b1, ack: 1'b0};

   // Driver levels for each state; the error condition always forces the safe levels.
   function automatic drv_t state_drv(input state_e s, input logic in_err);
      drv_t d;
      d = DRV_SAFE;
      if (!in_err) begin
         case (s)
            ST_OFF:    d = DRV_SAFE;
            ST_PUP:    d = '{pwr_en: 1'b1, dom_nreset: 1'b0, iso_en: 1'b1, ack: 1'b0};
            ST_RSTREL: d = '{pwr_en: 1'b1, dom_nreset: 1'b1, iso_en: 1'b1, ack: 1'b0};
            ST_ISOREL: d = '{pwr_en: 1'b1, dom_nreset: 1'b1, iso_en: 1'b0, ack: 1'b0};
            ST_ON:     d = '{pwr_en: 1'b1, dom_nreset: 1'b1, iso_en: 1'b0, ack: 1'b1};
            ST_ISOSET: d = '{pwr_en: 1'b1, dom_nreset: 1'b1, iso_en: 1'b1, ack: 1'b0};
            ST_RSTSET: d = '{pwr_en: 1'b1, dom_nreset: 1'b0, iso_en: 1'b1, ack: 1'b0};
            ST_PDN:    d = DRV_SAFE;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/la_dsync.sv
// Two-stage synchronizer for a single asynchronous level, synchronous active-high reset.
// Ports: clk/rst (always-on clock and reset), d_i (asynchronous input), q_o (synchronized output).
// Latency is two clk edges from a stable input to q_o; the stages reset to 0.
module la_dsync #(
   parameter PROP = "DEFAULT"
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   if (PROP == "DEFAULT") begin : g_generic
      always_ff @(posedge clk) begin
         if (rst) sync_q <= 2'b00;
         else     sync_q <= {sync_q[0], d_i};
      end
   end else begin : g_mapped
      // Same flop chain; the mapping flow retargets this scope to the library
      // synchronizer cell selected by PROP.
      always_ff @(posedge clk) begin
         if (rst) sync_q <= 2'b00;
         else     sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/la_pwrseq.sv
// Power-domain sequencer: level request -> ordered switch / reset / isolation sequence.
// Ports: clk, rst (sync, active-high), req (level on-request), pwr_good (async supply good);
// outputs pwr_en, dom_nreset, iso_en, ack, err (sticky) and state (debug; reads 0 in error).
module la_pwrseq
   import la_pwrseq_pkg::*;
#(
   parameter     PROP          = "DEFAULT",
   parameter int CW            = DEF_CW,
   parameter int SWITCH_CYCLES = DEF_SWITCH_CYCLES,
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int ISO_CYCLES    = DEF_ISO_CYCLES,
   parameter int TIMEOUT       = DEF_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       pwr_good,
   output logic       pwr_en,
   output logic       dom_nreset,
   output logic       iso_en,
   output logic       ack,
   output logic       err,
   output logic [2:0] state
);

   localparam logic [CW-1:0] SW_LAST  = CW'(SWITCH_CYCLES - 1);
   localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] ISO_LAST = CW'(ISO_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          in_err_q, in_err_d;   // error condition; state_q parks at ST_OFF meanwhile
   logic [CW-1:0] cnt_q, cnt_d;
   drv_t          drv_q;
   logic          err_q;
   logic          pg_s;
   logic          entering;

   la_dsync #(.PROP(PROP)) u_pg_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pwr_good),
      .q_o (pg_s)
   );

   always_comb begin
      state_d  = state_q;
      in_err_d = in_err_q;
      if (in_err_q) begin
         if (!req) in_err_d = 1'b0;
      end else begin
         case (state_q)
            ST_OFF:    if (req) state_d = ST_PUP;
            ST_PUP: begin
               if (cnt_q >= SW_LAST && pg_s) begin
                  state_d = ST_RSTREL;
               end else if (cnt_q == TO_LAST) begin
                  state_d  = ST_OFF;
                  in_err_d = 1'b1;
               end
            end
            ST_RSTREL: if (cnt_q == RST_LAST) state_d = ST_ISOREL;
            ST_ISOREL: if (cnt_q == ISO_LAST) state_d = ST_ON;
            ST_ON: begin
               // Supply loss outranks a power-down request.
               if (!pg_s) begin
                  state_d  = ST_OFF;
                  in_err_d = 1'b1;
               end else if (!req) begin
                  state_d = ST_ISOSET;
               end
            end
            ST_ISOSET: if (cnt_q == ISO_LAST) state_d = ST_RSTSET;
            ST_RSTSET: if (cnt_q == RST_LAST) state_d = ST_PDN;
            ST_PDN: begin
               if (cnt_q >= SW_LAST && !pg_s) begin
                  state_d = ST_OFF;
               end else if (cnt_q == TO_LAST) begin
                  state_d  = ST_OFF;
                  in_err_d = 1'b1;
               end
            end
         endcase
      end

      // Error entry/exit counts as a state entry even though state_q may not change.
      entering = (state_d != state_q) || (in_err_d != in_err_q);
      if (entering)
         cnt_d = '0;
      else if (!in_err_q && state_q != ST_OFF && state_q != ST_ON)
         cnt_d = cnt_q + CW'(1);
      else
         cnt_d = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_OFF;
         in_err_q <= 1'b0;
         cnt_q    <= '0;
         drv_q    <= DRV_SAFE;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         in_err_q <= in_err_d;
         cnt_q    <= cnt_d;
         // Outputs are registered from the current state, so they trail state by one cycle.
         drv_q    <= state_drv(state_q, in_err_q);
         err_q    <= err_q | in_err_q;
      end
   end

   assign pwr_en     = drv_q.pwr_en;
   assign dom_nreset = drv_q.dom_nreset;
   assign iso_en     = drv_q.iso_en;
   assign ack        = drv_q.ack;
   assign err        = err_q;
   assign state      = state_q;

endmodule

// File: tb/tb_la_pwrseq.sv
module tb_la_pwrseq;

   localparam int SW  = 4;
   localparam int RC  = 2;
   localparam int IC  = 3;
   localparam int TO  = 16;

   logic       clk;
   logic       rst;
   logic       req;
   logic       pwr_good;
   logic       pwr_en;
   logic       dom_nreset;
   logic       iso_en;
   logic       ack;
   logic       err;
   logic [2:0] state;

   la_pwrseq #(
      .PROP("DEFAULT"), .CW(8), .SWITCH_CYCLES(SW), .RST_CYCLES(RC),
      .ISO_CYCLES(IC), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .pwr_good(pwr_good),
      .pwr_en(pwr_en), .dom_nreset(dom_nreset), .iso_en(iso_en),
      .ack(ack), .err(err), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
   endtask

   // ---------------- behavioural reference model ----------------
   // Phase numbers follow the documented state codes; phase 8 is the error hold.
   // dwell counts cycles already spent in the current phase.
   int         m_ph;
   int         m_dwell;
   int         m_nxt;
   int         m_d;
   logic       m_pg1, m_pg2;
   logic [3:0] e_out;   // {pwr_en, dom_nreset, iso_en, ack}
   logic       e_err;
   logic [2:0] e_state;
   bit         chk_en = 0;

   function automatic logic [3:0] lvl(input int ph);
      logic [3:0] tbl [0:8];
      tbl = '{4'b0010, 4'b1010, 4'b1110, 4'b1100, 4'b1101, 4'b1110, 4'b1010, 4'b0010, 4'b0010};
      return tbl[ph];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ph = 0; m_dwell = 0; m_pg1 = 0; m_pg2 = 0;
         e_out = 4'b0010; e_err = 0;
      end else begin
         e_out = lvl(m_ph);
         if (m_ph == 8) e_err = 1;
         m_d   = m_dwell + 1;
         m_nxt = m_ph;
         case (m_ph)
            0: if (req) m_nxt = 1;
            1: if (m_d >= SW && m_pg2) m_nxt = 2; else if (m_d == TO) m_nxt = 8;
            2: if (m_d == RC) m_nxt = 3;
            3: if (m_d == IC) m_nxt = 4;
            4: if (!m_pg2) m_nxt = 8; else if (!req) m_nxt = 5;
            5: if (m_d == IC) m_nxt = 6;
            6: if (m_d == RC) m_nxt = 7;
            7: if (m_d >= SW && !m_pg2) m_nxt = 0; else if (m_d == TO) m_nxt = 8;
            default: if (!req) m_nxt = 0;
         endcase
         m_dwell = (m_nxt == m_ph) ? m_d : 0;
         m_ph    = m_nxt;
         m_pg2   = m_pg1;
         m_pg1   = pwr_good;
      end
      e_state = (m_ph == 8) ? 3'd0 : m_ph[2:0];
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_pwr_en",     pwr_en,     e_out[3]);
         chk("cyc_dom_nreset", dom_nreset, e_out[2]);
         chk("cyc_iso_en",     iso_en,     e_out[1]);
         chk("cyc_ack",        ack,        e_out[0]);
         chk("cyc_err",        err,        e_err);
         chk("cyc_state",      state,      e_state);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Optional supply model: pwr_good follows pwr_en with a lag of `lag` cycles.
   bit          follow = 0;
   int          lag    = 1;
   logic [31:0] pg_hist = '0;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      pg_hist = {pg_hist[30:0], pwr_en};
      if (follow) pwr_good = pg_hist[lag];
   endtask

   int k_a, k_b, k_c, k_d, k_e;
   bit saw;

   initial begin
      rst = 1; req = 0; pwr_good = 0;
      tick(); tick();
      chk_en = 1;
      tick();
      chk("rst_pwr_en", pwr_en, 0);
      chk("rst_iso_en", iso_en, 1);
      chk("rst_nreset", dom_nreset, 0);
      chk("rst_state",  state, 0);
      chk("rst_err",    err, 0);
      rst = 0;

      // 1: power-up with pwr_good already high
      pwr_good = 1;
      repeat (3) tick();
      req = 1;
      k_a = -1; k_b = -1; k_c = -1; k_d = -1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (k_a < 0 && pwr_en)     k_a = k;
         if (k_b < 0 && dom_nreset) k_b = k;
         if (k_c < 0 && !iso_en)    k_c = k;
         if (k_d < 0 && ack)        k_d = k;
      end
      chk("t1_pwr_en_rise",  k_a, 1);
      chk("t1_nreset_rise",  k_b, 5);
      chk("t1_iso_fall",     k_c, 7);
      chk("t1_ack_latency",  k_d, 10);

      // 2: power-down, supply drops one cycle after pwr_en falls
      req = 0;
      k_a = -1; k_b = -1; k_c = -1; k_d = -1; k_e = -1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (k_a < 0 && iso_en)      k_a = k;
         if (k_b < 0 && !ack)        k_b = k;
         if (k_c < 0 && !dom_nreset) k_c = k;
         if (k_d < 0 && !pwr_en) begin k_d = k; pwr_good = 0; end
         if (k_e < 0 && state == 3'd0) k_e = k;
      end
      chk("t2_iso_rise",  k_a, 1);
      chk("t2_ack_fall",  k_b, 1);
      chk("t2_nreset",    k_c, 4);
      chk("t2_pwr_en",    k_d, 6);
      chk("t2_off_reach", k_e, 9);
      chk("t2_no_err",    err, 0);

      // 5: request withdrawn during RSTREL still completes to ON, then powers down
      follow = 1; lag = 2; req = 1;
      for (int k = 0; k < 40 && state != 3'd2; k++) tick();
      chk("t5_in_rstrel", state, 2);
      req = 0;
      saw = 0; k_e = -1;
      for (int k = 0; k < 80; k++) begin
         tick();
         if (ack) saw = 1;
         if (saw && k_e < 0 && state == 3'd0) k_e = k;
      end
      chk("t5_saw_ack", saw, 1);
      chk("t5_back_off", (k_e >= 0) && !pwr_en, 1);
      chk("t5_no_err", err, 0);

      // 6: reset during ISOREL
      lag = 0; req = 1;
      for (int k = 0; k < 40 && state != 3'd3; k++) tick();
      chk("t6_in_isorel", state, 3);
      rst = 1;
      tick();
      chk("t6_pwr_en", pwr_en, 0);
      chk("t6_nreset", dom_nreset, 0);
      chk("t6_iso",    iso_en, 1);
      chk("t6_ack",    ack, 0);
      chk("t6_state",  state, 0);
      rst = 0;
      k_a = -1;
      for (int k = 0; k < 10 && k_a < 0; k++) begin
         tick();
         if (pwr_en) k_a = k;
      end
      chk("t6_restart", k_a, 1);

      // 4: supply glitch while ON
      for (int k = 0; k < 40 && !ack; k++) tick();
      chk("t4_on", ack, 1);
      follow = 0; pwr_good = 0;
      k_a = -1; k_b = -1;
      for (int k = 1; k < 12; k++) begin
         tick();
         if (k == 3) pwr_good = 1;
         if (k_a < 0 && state == 3'd0) k_a = k;
         if (k_b < 0 && err) k_b = k;
      end
      chk("t4_err_state", k_a, 3);
      chk("t4_err_flag",  k_b, 4);
      chk("t4_iso",       iso_en, 1);
      chk("t4_nreset",    dom_nreset, 0);
      req = 0;
      repeat (3) tick();
      rst = 1; tick(); rst = 0;

      // 3: supply never comes up -> timeout
      pwr_good = 0; req = 1;
      k_a = -1; k_b = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (k_a < 0 && err) begin k_a = k; k_b = pwr_en; end
      end
      chk("t3_err_time", k_a, 17);
      chk("t3_pwr_en",   k_b, 0);
      chk("t3_hold_st",  state, 0);
      req = 0;
      repeat (3) tick();
      chk("t3_err_sticky", err, 1);
      chk("t3_off",        state, 0);
      rst = 1; tick(); rst = 0;

      // randomized phase, checked every cycle against the model
      for (int blk = 0; blk < 20; blk++) begin
         follow = ($urandom_range(0, 3) != 0);
         lag    = $urandom_range(0, 20);
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 11) == 0) req = ~req;
            if (!follow && $urandom_range(0, 19) == 0) pwr_good = ~pwr_good;
            rst = ($urandom_range(0, 399) == 0);
            tick();
         end
      end
      rst = 0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
